// File: rtl/gray_to_binary.sv
// Registered Gray-to-binary converter that also flags multi-bit jumps
// between consecutive accepted Gray samples.
module gray_to_binary #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] binary_out,
    output logic             out_valid,
    output logic             step_err
);

    logic [WIDTH-1:0] prev_gray;
    logic             have_prev;
    logic [WIDTH-1:0] bin_c;
    logic [WIDTH-1:0] diff_c;
    logic             multi_bit_c;

    // Prefix XOR from the MSB: binary bit i is the parity of gray bits i and above.
    always_comb begin
        bin_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin_c[i] = ^(gray_in >> i);
        end
    end

    // Two or more differing bits <=> clearing the lowest set bit leaves something set.
    always_comb begin
        diff_c      = gray_in ^ prev_gray;
        multi_bit_c = |(diff_c & (diff_c - WIDTH'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            binary_out <= '0;
            out_valid  <= 1'b0;
            step_err   <= 1'b0;
            prev_gray  <= '0;
            have_prev  <= 1'b0;
        end else if (in_valid) begin
            binary_out <= bin_c;
            out_valid  <= 1'b1;
            step_err   <= have_prev & multi_bit_c;
            prev_gray  <= gray_in;
            have_prev  <= 1'b1;
        end else begin
            out_valid  <= 1'b0;
            step_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_to_binary.sv
// Directed bench for gray_to_binary at WIDTH=4 and WIDTH=8.
module tb_gray_to_binary;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid4 = 1'b0;
    logic [3:0] gray4 = '0;
    logic [3:0] bin4;
    logic       ov4, err4;
    logic       in_valid8 = 1'b0;
    logic [7:0] gray8 = '0;
    logic [7:0] bin8;
    logic       ov8, err8;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    gray_to_binary #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .gray_in(gray4),
        .binary_out(bin4), .out_valid(ov4), .step_err(err4)
    );

    gray_to_binary #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .gray_in(gray8),
        .binary_out(bin8), .out_valid(ov8), .step_err(err8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the 4-bit DUT, then sample just after the edge.
    task automatic step4(input logic v, input logic [3:0] g);
        in_valid4 = v;
        gray4     = g;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic v, input logic [7:0] g);
        in_valid8 = v;
        gray8     = g;
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string tag, input logic [3:0] b, input logic v, input logic e);
        check({tag, ".bin"}, 32'(bin4), 32'(b));
        check({tag, ".ov"},  32'(ov4),  32'(v));
        check({tag, ".err"}, 32'(err4), 32'(e));
    endtask

    task automatic expect8(input string tag, input logic [7:0] b, input logic v, input logic e);
        check({tag, ".bin"}, 32'(bin8), 32'(b));
        check({tag, ".ov"},  32'(ov8),  32'(v));
        check({tag, ".err"}, 32'(err8), 32'(e));
    endtask

    // Mid-cycle asynchronous reset pulse, released between edges.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        expect4("rst_async4", 4'h0, 1'b0, 1'b0);
        expect8("rst_async8", 8'h00, 1'b0, 1'b0);
        in_valid4 = 1'b0;
        in_valid8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] seq_gray [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};

    initial begin
        // Reset held from time zero
        #12;
        expect4("rst_init", 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step4(1'b0, 4'hF);
            expect4($sformatf("idle_after_rst%0d", k), 4'h0, 1'b0, 1'b0);
        end

        // Counting sequence 0..9
        for (int k = 0; k < 10; k++) begin
            step4(1'b1, seq_gray[k]);
            expect4($sformatf("seq%0d", k), 4'(k), 1'b1, 1'b0);
        end

        // Reset mid-stream: the in-flight sample and history are discarded
        pulse_reset();
        step4(1'b0, 4'h0);
        expect4("post_rst_idle", 4'h0, 1'b0, 1'b0);

        // Illegal jump after fresh reset
        step4(1'b1, 4'b0010);
        expect4("jump_a", 4'b0011, 1'b1, 1'b0);
        step4(1'b1, 4'b0000);
        expect4("jump_b", 4'b0000, 1'b1, 1'b0);
        step4(1'b1, 4'b0110);
        expect4("jump_c", 4'b0100, 1'b1, 1'b1);

        // Repeat and gaps (0110 -> 0101 differs in two bits)
        step4(1'b1, 4'b0101);
        expect4("gap_first", 4'b0110, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step4(1'b0, 4'b1111);
            expect4($sformatf("gap_idle%0d", k), 4'b0110, 1'b0, 1'b0);
        end
        step4(1'b1, 4'b0101);
        expect4("gap_repeat", 4'b0110, 1'b1, 1'b0);
        step4(1'b1, 4'b0000);
        expect4("gap_jump", 4'b0000, 1'b1, 1'b1);

        // All 16 codes in Gray order, then the wrap back to 0000
        for (int k = 0; k < 16; k++) begin
            logic [3:0] g;
            g = 4'(k) ^ (4'(k) >> 1);
            step4(1'b1, g);
            expect4($sformatf("exh%0d", k), 4'(k), 1'b1, 1'b0);
        end
        step4(1'b1, 4'b0000);
        expect4("exh_wrap", 4'b0000, 1'b1, 1'b0);
        in_valid4 = 1'b0;

        // WIDTH=8 checks
        pulse_reset();
        step8(1'b1, 8'b1000_0000);
        expect8("w8_msb", 8'b1111_1111, 1'b1, 1'b0);
        pulse_reset();
        step8(1'b1, 8'hFF);
        expect8("w8_ff", 8'hAA, 1'b1, 1'b0);
        step8(1'b1, 8'h00);
        expect8("w8_00", 8'h00, 1'b1, 1'b1);
        step8(1'b0, 8'h00);
        expect8("w8_idle", 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
